pipe_controller: RTL and testbench

- Parametrised successor to the single-cycle decode controller for the 3-stage RV32I core (IF | ID/EX | WB).
- Decodes the ID/EX instruction into combinational EX controls and registers the WB-stage controls.
- Sequences multi-cycle MUL/DIV stalls, branch/jump/mret redirect flushes, and interrupt/illegal-instruction traps through a small FSM.
- Every output is defined on every path; the block contains no latches.

---
 rtl/pipe_controller.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_pipe_controller.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// Decode and hazard controller for the 3-stage RV32I core (IF | ID/EX | WB): combinational
// EX controls, registered WB controls, and an FSM sequencing MDU stalls and trap entry.
module pipe_controller #(
  parameter int EN_MEXT = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic        inst_valid_i,
  input  logic        br_taken_i,
  input  logic        irq_i,
  input  logic        mie_i,
  output logic        sel_opr_a,
  output logic        sel_opr_b,
  output logic [3:0]  aluop,
  output logic [2:0]  imm_type,
  output logic [2:0]  br_type,
  output logic [2:0]  mem_type,
  output logic        wr_en,
  output logic        csr_rd,
  output logic        sel_pc,
  output logic        mdu_start,
  output logic [2:0]  mdu_op,
  output logic        stall_o,
  output logic        flush_o,
  output logic        is_mret,
  output logic        trap_o,
  output logic [1:0]  trap_cause,
  output logic        wb_rf_en,
  output logic        wb_rd_en,
  output logic        wb_csr_wr,
  output logic [1:0]  wb_sel_wb
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] MRET_INST = 32'h3020_0073;

  localparam logic MUL_MULTI = (MUL_LAT >= 2);
  localparam logic DIV_MULTI = (DIV_LAT >= 2);
  localparam logic [CNT_W-1:0] MUL_CNT = (MUL_LAT >= 2) ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_CNT = (DIV_LAT >= 2) ? CNT_W'(DIV_LAT - 2) : '0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010, ALU_SLT = 4'b0011,
    ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111,
    ALU_OR = 4'b1000, ALU_AND = 4'b1001, ALU_PASSB = 4'b1010
  } alu_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_J = 3'b001, IMM_U = 3'b010, IMM_B = 3'b011, IMM_S = 3'b100
  } imm_t;

  typedef enum logic [1:0] {S_RUN, S_BUSY, S_TRAP} state_t;

  typedef struct packed {
    logic       rf_en;
    logic       rd_en;
    logic       csr_wr;
    logic [1:0] sel_wb;
  } wb_t;

  typedef struct packed {
    logic       legal;
    logic       sel_opr_a;
    logic       sel_opr_b;
    alu_t       aluop;
    imm_t       imm_type;
    logic [2:0] br_type;
    logic [2:0] mem_type;
    logic [2:0] mdu_op;
    logic       wr_en;
    logic       csr_rd;
    logic       is_branch;
    logic       is_jump;
    logic       is_mret;
    logic       is_mop;
    wb_t        wb;
  } dec_t;

  function automatic alu_t alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [2:0] br_of(input logic [2:0] f3);
    case (f3)
      3'b001:  return 3'b001;
      3'b100:  return 3'b010;
      3'b101:  return 3'b011;
      3'b110:  return 3'b100;
      3'b111:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] mem_of(input logic [2:0] f3);
    case (f3)
      3'b001:  return 3'b001;
      3'b010:  return 3'b010;
      3'b100:  return 3'b011;
      3'b101:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  dec_t       dec;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin : decode
    dec       = '0;
    dec.legal = 1'b1;
    case (opcode)
      OP_REG: begin
        dec.wb.rf_en = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.aluop = alu_of(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.aluop = alu_of(funct3, 1'b1);
        end else if (funct7 == 7'b0000001 && EN_MEXT != 0) begin
          dec.is_mop = 1'b1;
          dec.mdu_op = funct3;
        end else begin
          dec.legal = 1'b0;
        end
      end
      OP_IMM: begin
        dec.sel_opr_b = 1'b1;
        dec.aluop     = alu_of(funct3, funct3 == 3'b101 && inst_i[30]);
        dec.wb.rf_en  = 1'b1;
      end
      OP_LOAD: begin
        dec.sel_opr_b = 1'b1;
        dec.mem_type  = mem_of(funct3);
        dec.wb        = '{rf_en: 1'b1, rd_en: 1'b1, csr_wr: 1'b0, sel_wb: 2'b01};
      end
      OP_STORE: begin
        dec.sel_opr_b = 1'b1;
        dec.imm_type  = IMM_S;
        dec.mem_type  = mem_of(funct3);
        dec.wr_en     = 1'b1;
      end
      OP_BRANCH: begin
        dec.sel_opr_a = 1'b1;
        dec.sel_opr_b = 1'b1;
        dec.imm_type  = IMM_B;
        dec.br_type   = br_of(funct3);
        dec.is_branch = 1'b1;
      end
      OP_JAL: begin
        dec.sel_opr_a = 1'b1;
        dec.sel_opr_b = 1'b1;
        dec.imm_type  = IMM_J;
        dec.is_jump   = 1'b1;
        dec.wb        = '{rf_en: 1'b1, rd_en: 1'b0, csr_wr: 1'b0, sel_wb: 2'b10};
      end
      OP_JALR: begin
        dec.sel_opr_b = 1'b1;
        dec.is_jump   = 1'b1;
        dec.wb        = '{rf_en: 1'b1, rd_en: 1'b0, csr_wr: 1'b0, sel_wb: 2'b10};
      end
      OP_LUI: begin
        dec.sel_opr_b = 1'b1;
        dec.imm_type  = IMM_U;
        dec.aluop     = ALU_PASSB;
        dec.wb.rf_en  = 1'b1;
      end
      OP_AUIPC: begin
        dec.sel_opr_a = 1'b1;
        dec.sel_opr_b = 1'b1;
        dec.imm_type  = IMM_U;
        dec.wb.rf_en  = 1'b1;
      end
      OP_SYSTEM: begin
        if (inst_i == MRET_INST) begin
          dec.is_mret = 1'b1;
        end else if (funct3 == 3'b001) begin
          dec.csr_rd = 1'b1;
          dec.wb     = '{rf_en: 1'b1, rd_en: 1'b0, csr_wr: 1'b1, sel_wb: 2'b11};
        end else begin
          dec.legal = 1'b0;
        end
      end
      default: dec.legal = 1'b0;
    endcase
    // An illegal instruction shows no decoded fields at all.
    if (!dec.legal) dec = '0;
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_t              wb_q, wb_d;
  logic             mop_multi;
  logic [CNT_W-1:0] mop_cnt;
  logic             show;

  assign mop_multi = funct3[2] ? DIV_MULTI : MUL_MULTI;
  assign mop_cnt   = funct3[2] ? DIV_CNT : MUL_CNT;

  always_comb begin : control
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    sel_opr_a  = 1'b0;
    sel_opr_b  = 1'b0;
    aluop      = 4'b0000;
    imm_type   = 3'b000;
    br_type    = 3'b000;
    mem_type   = 3'b000;
    mdu_op     = 3'b000;
    wr_en      = 1'b0;
    csr_rd     = 1'b0;
    sel_pc     = 1'b0;
    mdu_start  = 1'b0;
    stall_o    = 1'b0;
    flush_o    = 1'b0;
    is_mret    = 1'b0;
    trap_o     = 1'b0;
    trap_cause = 2'b00;
    show       = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_d       = '0;

    if (!rst) begin
      unique case (state_q)
        S_RUN: begin
          if (inst_valid_i) begin
            show = 1'b1;
            if (!dec.legal || (irq_i && mie_i)) begin
              trap_o     = 1'b1;
              trap_cause = dec.legal ? 2'b10 : 2'b01;
              sel_pc     = 1'b1;
              flush_o    = 1'b1;
              state_d    = S_TRAP;
            end else begin
              wr_en  = dec.wr_en;
              csr_rd = dec.csr_rd;
              wb_d   = dec.wb;
              if (dec.is_mret) begin
                is_mret = 1'b1;
                sel_pc  = 1'b1;
                flush_o = 1'b1;
              end else if (dec.is_jump || (dec.is_branch && br_taken_i)) begin
                sel_pc  = 1'b1;
                flush_o = 1'b1;
              end else if (dec.is_mop) begin
                mdu_start = 1'b1;
                if (mop_multi) begin
                  stall_o = 1'b1;
                  cnt_d   = mop_cnt;
                  wb_d    = '0;
                  state_d = S_BUSY;
                end
              end
            end
          end
        end
        S_BUSY: begin
          // The held M-op keeps driving its fields; interrupts wait for RUN.
          show = 1'b1;
          if (cnt_q != '0) begin
            stall_o = 1'b1;
            cnt_d   = cnt_q - 1'b1;
          end else begin
            wb_d    = '{rf_en: 1'b1, rd_en: 1'b0, csr_wr: 1'b0, sel_wb: 2'b00};
            state_d = S_RUN;
          end
        end
        S_TRAP: begin
          flush_o = 1'b1;
          state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end

    if (show) begin
      sel_opr_a = dec.sel_opr_a;
      sel_opr_b = dec.sel_opr_b;
      aluop     = dec.aluop;
      imm_type  = dec.imm_type;
      br_type   = dec.br_type;
      mem_type  = dec.mem_type;
      mdu_op    = dec.mdu_op;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

  assign wb_rf_en  = wb_q.rf_en;
  assign wb_rd_en  = wb_q.rd_en;
  assign wb_csr_wr = wb_q.csr_wr;
  assign wb_sel_wb = wb_q.sel_wb;

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: directed scenarios plus randomized instruction
// streams compared every cycle against an instruction-class behavioural model.
module tb_pipe_controller;

  localparam int EN_MEXT = 1;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        inst_valid_i, br_taken_i, irq_i, mie_i;
  logic        sel_opr_a, sel_opr_b, wr_en, csr_rd, sel_pc, mdu_start;
  logic        stall_o, flush_o, is_mret, trap_o, wb_rf_en, wb_rd_en, wb_csr_wr;
  logic [3:0]  aluop;
  logic [2:0]  imm_type, br_type, mem_type, mdu_op;
  logic [1:0]  trap_cause, wb_sel_wb;

  always #5 clk = ~clk;

  pipe_controller #(
    .EN_MEXT(EN_MEXT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .br_taken_i(br_taken_i), .irq_i(irq_i), .mie_i(mie_i),
    .sel_opr_a(sel_opr_a), .sel_opr_b(sel_opr_b), .aluop(aluop), .imm_type(imm_type),
    .br_type(br_type), .mem_type(mem_type), .wr_en(wr_en), .csr_rd(csr_rd),
    .sel_pc(sel_pc), .mdu_start(mdu_start), .mdu_op(mdu_op), .stall_o(stall_o),
    .flush_o(flush_o), .is_mret(is_mret), .trap_o(trap_o), .trap_cause(trap_cause),
    .wb_rf_en(wb_rf_en), .wb_rd_en(wb_rd_en), .wb_csr_wr(wb_csr_wr), .wb_sel_wb(wb_sel_wb)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {C_ILL, C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC,
                C_CSR, C_MRET, C_MOP} cls_t;

  typedef struct packed {
    logic sel_a, sel_b; logic [3:0] alu; logic [2:0] imm, br, mem, mop;
    logic wr, csr, pc, start, stall, flush, mret, trap; logic [1:0] cause;
  } exp_t;

  typedef struct packed {logic rf, rd, csrw; logic [1:0] sel;} wbx_t;

  int alu_tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  int br_tbl[8]  = '{0, 1, 0, 0, 2, 3, 4, 5};
  int mem_tbl[8] = '{0, 1, 2, 0, 3, 4, 0, 0};

  function automatic cls_t classify(input logic [31:0] x);
    logic [2:0] f3 = x[14:12];
    logic [6:0] f7 = x[31:25];
    case (x[6:0])
      7'h33: begin
        if (f7 == 7'h00) return C_R;
        if (f7 == 7'h20) return (f3 == 3'd0 || f3 == 3'd5) ? C_R : C_ILL;
        if (f7 == 7'h01) return (EN_MEXT != 0) ? C_MOP : C_ILL;
        return C_ILL;
      end
      7'h13: return C_I;
      7'h03: return C_LD;
      7'h23: return C_ST;
      7'h63: return C_BR;
      7'h6F: return C_JAL;
      7'h67: return C_JALR;
      7'h37: return C_LUI;
      7'h17: return C_AUIPC;
      7'h73: begin
        if (x == 32'h3020_0073) return C_MRET;
        return (f3 == 3'd1) ? C_CSR : C_ILL;
      end
      default: return C_ILL;
    endcase
  endfunction

  // Decoded fields, commit record and EX enables for one instruction.
  function automatic void fields(input logic [31:0] x, output exp_t e, output wbx_t w,
                                 output logic wr, output logic cr);
    logic [2:0] f3 = x[14:12];
    e = '0; w = '0; wr = 1'b0; cr = 1'b0;
    case (classify(x))
      C_R:     begin e.alu = x[30] ? ((f3 == 3'd0) ? 4'd1 : 4'd7) : 4'(alu_tbl[f3]); w.rf = 1; end
      C_I:     begin e.sel_b = 1; e.alu = (f3 == 3'd5 && x[30]) ? 4'd7 : 4'(alu_tbl[f3]); w.rf = 1; end
      C_LD:    begin e.sel_b = 1; e.mem = 3'(mem_tbl[f3]); w.rf = 1; w.rd = 1; w.sel = 2'd1; end
      C_ST:    begin e.sel_b = 1; e.imm = 3'd4; e.mem = 3'(mem_tbl[f3]); wr = 1; end
      C_BR:    begin e.sel_a = 1; e.sel_b = 1; e.imm = 3'd3; e.br = 3'(br_tbl[f3]); end
      C_JAL:   begin e.sel_a = 1; e.sel_b = 1; e.imm = 3'd1; w.rf = 1; w.sel = 2'd2; end
      C_JALR:  begin e.sel_b = 1; w.rf = 1; w.sel = 2'd2; end
      C_LUI:   begin e.sel_b = 1; e.imm = 3'd2; e.alu = 4'd10; w.rf = 1; end
      C_AUIPC: begin e.sel_a = 1; e.sel_b = 1; e.imm = 3'd2; w.rf = 1; end
      C_CSR:   begin cr = 1; w.rf = 1; w.csrw = 1; w.sel = 2'd3; end
      C_MOP:   begin e.mop = f3; w.rf = 1; end
      default: ;
    endcase
  endfunction

  // Model state: mode 0 = accepting, 1 = M-op in flight, 2 = trap-entry cycle next.
  int   mode = 0, mop_k = 0, mop_lat = 0;
  int   n_mode, n_k, n_lat;
  wbx_t m_wb = '0, n_wb;
  exp_t ex;
  logic cmp_en = 1'b0;

  task automatic model_eval();
    exp_t f; wbx_t w; logic wr, cr; cls_t c; int lat;
    ex = '0; n_wb = '0; n_mode = 0; n_k = 0; n_lat = mop_lat;
    if (rst) return;
    if (mode == 2) begin
      ex.flush = 1;
    end else if (mode == 1) begin
      fields(inst_i, f, w, wr, cr);
      ex = f;
      if (mop_k < mop_lat - 1) begin
        ex.stall = 1; n_mode = 1; n_k = mop_k + 1;
      end else begin
        n_wb = '{rf: 1'b1, rd: 1'b0, csrw: 1'b0, sel: 2'd0};
      end
    end else if (inst_valid_i) begin
      fields(inst_i, f, w, wr, cr);
      ex = f;
      c  = classify(inst_i);
      if (c == C_ILL || (irq_i && mie_i)) begin
        ex.trap = 1; ex.cause = (c == C_ILL) ? 2'd1 : 2'd2; ex.pc = 1; ex.flush = 1;
        n_mode = 2;
      end else begin
        ex.wr = wr; ex.csr = cr; n_wb = w;
        if (c == C_MRET) begin
          ex.mret = 1; ex.pc = 1; ex.flush = 1;
        end else if (c == C_JAL || c == C_JALR || (c == C_BR && br_taken_i)) begin
          ex.pc = 1; ex.flush = 1;
        end else if (c == C_MOP) begin
          ex.start = 1;
          lat = inst_i[14] ? DIV_LAT : MUL_LAT;
          if (lat >= 2) begin
            ex.stall = 1; n_wb = '0; n_mode = 1; n_k = 1; n_lat = lat;
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    mode = n_mode; mop_k = n_k; mop_lat = n_lat; m_wb = n_wb;
  endtask

  task automatic compare_all();
    check("sel_opr_a", sel_opr_a, ex.sel_a);
    check("sel_opr_b", sel_opr_b, ex.sel_b);
    check("aluop", aluop, ex.alu);
    check("imm_type", imm_type, ex.imm);
    check("br_type", br_type, ex.br);
    check("mem_type", mem_type, ex.mem);
    check("mdu_op", mdu_op, ex.mop);
    check("wr_en", wr_en, ex.wr);
    check("csr_rd", csr_rd, ex.csr);
    check("sel_pc", sel_pc, ex.pc);
    check("mdu_start", mdu_start, ex.start);
    check("stall_o", stall_o, ex.stall);
    check("flush_o", flush_o, ex.flush);
    check("is_mret", is_mret, ex.mret);
    check("trap_o", trap_o, ex.trap);
    check("trap_cause", trap_cause, ex.cause);
    check("wb_rf_en", wb_rf_en, m_wb.rf);
    check("wb_rd_en", wb_rd_en, m_wb.rd);
    check("wb_csr_wr", wb_csr_wr, m_wb.csrw);
    check("wb_sel_wb", wb_sel_wb, m_wb.sel);
  endtask

  always @(negedge clk) if (cmp_en) compare_all();

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic r, input logic [31:0] x, input logic v, input logic bt,
                      input logic iq, input logic me);
    rst = r; inst_i = x; inst_valid_i = v; br_taken_i = bt; irq_i = iq; mie_i = me;
    model_eval();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom();
    int          ld_f3[5] = '{0, 1, 2, 4, 5};
    int          br_f3[6] = '{0, 1, 4, 5, 6, 7};
    logic [2:0]  f3;
    case ($urandom_range(0, 18))
      0, 1: begin
        f3 = r[14:12];
        if (r[0] && (f3 == 3'd0 || f3 == 3'd5)) return {7'h20, r[24:15], f3, r[11:7], 7'h33};
        return {7'h00, r[24:15], f3, r[11:7], 7'h33};
      end
      2:      return {r[31:7], 7'h33};
      3, 4:   return {r[31:7], 7'h13};
      5:      return {r[31:15], 3'(ld_f3[$urandom_range(0, 4)]), r[11:7], 7'h03};
      6:      return {r[31:15], 3'($urandom_range(0, 2)), r[11:7], 7'h23};
      7, 8:   return {r[31:15], 3'(br_f3[$urandom_range(0, 5)]), r[11:7], 7'h63};
      9:      return {r[31:7], 7'h6F};
      10:     return {r[31:15], 3'b000, r[11:7], 7'h67};
      11:     return {r[31:7], 7'h37};
      12:     return {r[31:7], 7'h17};
      13:     return {r[31:15], 3'b001, r[11:7], 7'h73};
      14:     return 32'h3020_0073;
      15:     return {r[31:7], 7'h73};
      16:     return {r[31:2], 2'b01};
      default: return {7'h01, r[24:15], r[14:12], r[11:7], 7'h33};
    endcase
  endfunction

  localparam logic [31:0] ADD  = 32'h0020_81B3;
  localparam logic [31:0] MUL  = 32'h0220_81B3;
  localparam logic [31:0] DIV  = 32'h0220_C1B3;
  localparam logic [31:0] BEQ  = 32'h0020_8463;
  localparam logic [31:0] BADO = 32'h0000_007F;
  localparam logic [31:0] MRET = 32'h3020_0073;
  localparam logic [31:0] ECAL = 32'h0000_0073;

  initial begin
    int          stall_cnt, trap_cnt;
    logic        hold, irq_s, mie_s, r;
    logic [31:0] cur;
    logic        cur_v;

    rst = 1'b1; inst_i = ADD; inst_valid_i = 1'b1; br_taken_i = 1'b0; irq_i = 1'b0; mie_i = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;

    // Reset: outputs quiet while rst is high, then ADD decodes and commits.
    step(1, ADD, 1, 0, 0, 1);
    check("rst_rf_en", wb_rf_en, 0);
    check("rst_sel_pc", sel_pc, 0);
    check("rst_sel_b", sel_opr_b, 0);
    tick();
    step(0, ADD, 1, 0, 0, 1);
    check("add_aluop", aluop, 4'b0000);
    check("add_sel_b", sel_opr_b, 0);
    tick();
    step(0, 32'h0, 0, 0, 0, 1);
    check("add_wb_rf", wb_rf_en, 1);
    check("add_wb_sel", wb_sel_wb, 2'b00);
    tick();

    // MUL with 3-cycle latency.
    step(0, MUL, 1, 0, 0, 1);
    check("mul_start_t", mdu_start, 1);
    check("mul_stall_t", stall_o, 1);
    check("mul_op", mdu_op, 3'b000);
    tick();
    step(0, MUL, 1, 0, 0, 1);
    check("mul_start_t1", mdu_start, 0);
    check("mul_stall_t1", stall_o, 1);
    tick();
    step(0, MUL, 1, 0, 0, 1);
    check("mul_stall_t2", stall_o, 0);
    check("mul_wb_t2", wb_rf_en, 0);
    tick();
    step(0, 32'h0, 0, 0, 0, 1);
    check("mul_wb_t3", wb_rf_en, 1);
    tick();

    // DIV with an interrupt raised mid-stall.
    stall_cnt = 0; trap_cnt = 0;
    for (int k = 0; k < 34; k++) begin
      step(0, DIV, 1, 0, k >= 5, 1);
      stall_cnt += int'(stall_o);
      trap_cnt  += int'(trap_o);
      tick();
    end
    check("div_stall_cycles", stall_cnt, 33);
    check("div_no_trap_busy", trap_cnt, 0);
    step(0, ADD, 1, 0, 1, 1);
    check("div_wb_t34", wb_rf_en, 1);
    check("irq_trap", trap_o, 1);
    check("irq_cause", trap_cause, 2'b10);
    tick();
    step(0, 32'h0, 0, 0, 0, 1);
    check("irq_trap_state_flush", flush_o, 1);
    tick();

    // Taken branch.
    step(0, BEQ, 1, 1, 0, 1);
    check("beq_sel_pc", sel_pc, 1);
    check("beq_flush", flush_o, 1);
    check("beq_br_type", br_type, 3'b000);
    check("beq_imm", imm_type, 3'b011);
    tick();
    step(0, 32'h0, 0, 0, 0, 1);
    check("beq_wb_rf", wb_rf_en, 0);
    tick();

    // Unknown opcode: trap, one TRAP cycle, back to RUN.
    step(0, BADO, 1, 0, 0, 1);
    check("ill_trap", trap_o, 1);
    check("ill_cause", trap_cause, 2'b01);
    check("ill_sel_pc", sel_pc, 1);
    tick();
    step(0, ADD, 1, 0, 0, 1);
    check("trapst_flush", flush_o, 1);
    check("trapst_trap", trap_o, 0);
    check("trapst_wb", wb_rf_en, 0);
    tick();
    step(0, ADD, 1, 0, 0, 1);
    check("run_again_flush", flush_o, 0);
    tick();

    // MRET and an unsupported SYSTEM encoding.
    step(0, MRET, 1, 0, 0, 1);
    check("mret_is", is_mret, 1);
    check("mret_pc", sel_pc, 1);
    check("mret_flush", flush_o, 1);
    tick();
    step(0, ECAL, 1, 0, 0, 1);
    check("ecall_trap", trap_o, 1);
    check("ecall_cause", trap_cause, 2'b01);
    tick();
    step(0, 32'h0, 0, 0, 0, 1);
    tick();

    // Reset in the middle of a DIV stall.
    for (int k = 0; k < 4; k++) begin
      step(0, DIV, 1, 0, 0, 1);
      tick();
    end
    step(1, DIV, 1, 0, 0, 1);
    check("rst_busy_stall", stall_o, 0);
    tick();
    step(0, 32'h0, 0, 0, 0, 1);
    check("post_rst_stall", stall_o, 0);
    check("post_rst_start", mdu_start, 0);
    check("post_rst_wb", wb_rf_en, 0);
    tick();

    // Randomized streams; the model's stall decides when the instruction is held.
    hold = 1'b0; irq_s = 1'b0; mie_s = 1'b0; cur = ADD; cur_v = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      if (!hold) begin
        cur_v = ($urandom_range(0, 7) != 0);
        cur   = rand_inst();
      end
      if ($urandom_range(0, 24) == 0) irq_s = ~irq_s;
      if ($urandom_range(0, 24) == 0) mie_s = ~mie_s;
      step(r, cur, cur_v, 1'($urandom_range(0, 1)), irq_s, mie_s);
      hold = ex.stall;
      tick();
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
